// File: rtl/avalon_st_timing_adapter_rl.sv
// Avalon-ST timing adapter: bridges source/sink with differing ready latencies (0..3)
// through a show-ahead register FIFO, reporting fill level and sticky beat loss.
module avalon_st_timing_adapter_rl #(
  parameter int DATA_WIDTH        = 32,
  parameter int ERROR_WIDTH       = 6,
  parameter int EMPTY_WIDTH       = 2,
  parameter int DEPTH             = 8,
  parameter int IN_READY_LATENCY  = 0,
  parameter int OUT_READY_LATENCY = 0,
  localparam int FILL_W           = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [ERROR_WIDTH-1:0] in_error,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [ERROR_WIDTH-1:0] out_error,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic [FILL_W-1:0]      fill_level,
  output logic                   overflow
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW     = DATA_WIDTH + ERROR_WIDTH + 2 + EMPTY_WIDTH;
  localparam int IN_HW  = (IN_READY_LATENCY > 0) ? IN_READY_LATENCY : 1;
  localparam int OUT_HW = (OUT_READY_LATENCY > 0) ? OUT_READY_LATENCY : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(DEPTH);
  localparam logic [FILL_W+1:0] DEPTH_EXT  = (FILL_W + 2)'(DEPTH);

  logic [PW-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic              overflow_reg, overflow_next;
  logic [IN_HW-1:0]  in_hist_reg, in_hist_next;
  logic [OUT_HW-1:0] out_hist_reg, out_hist_next;

  logic [2:0]        pend_in;
  logic [FILL_W+1:0] committed;
  logic              grant, push, pop, drop;
  logic              not_full, not_empty;
  logic [PW-1:0]     in_payload, head;

  assign in_payload = {in_data, in_error, in_startofpacket, in_endofpacket, in_empty};
  assign head       = mem_reg[rd_ptr_reg];
  assign {out_data, out_error, out_startofpacket, out_endofpacket, out_empty} = head;

  assign not_full   = (fill_reg != FULL_LEVEL);
  assign not_empty  = (fill_reg != '0);
  assign fill_level = fill_reg;
  assign overflow   = overflow_reg;

  // Grants still in flight must have space reserved, or a honoured grant could find us full.
  always_comb begin
    pend_in = '0;
    if (IN_READY_LATENCY > 0) begin
      for (int i = 0; i < IN_HW; i++) pend_in = pend_in + {2'b00, in_hist_reg[i]};
    end
  end

  assign committed = {2'b00, fill_reg} + (FILL_W + 2)'(pend_in);
  assign in_ready  = !reset && (committed < DEPTH_EXT);

  generate
    if (IN_READY_LATENCY == 0) begin : g_grant_rl0
      assign grant = in_ready;
    end else begin : g_grant_rln
      assign grant = in_hist_reg[IN_HW-1];
    end

    if (OUT_READY_LATENCY == 0) begin : g_out_rl0
      assign out_valid = !reset && not_empty;
      assign pop       = out_valid && out_ready;
    end else begin : g_out_rln
      // Sink committed to accept this cycle M cycles ago, so any valid beat is consumed.
      assign out_valid = !reset && not_empty && out_hist_reg[OUT_HW-1];
      assign pop       = out_valid;
    end
  endgenerate

  assign push = !reset && in_valid && grant && not_full;
  assign drop = !reset && in_valid &&
                (((IN_READY_LATENCY > 0) && !grant) || (grant && !not_full));

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    fill_next     = fill_reg;
    overflow_next = overflow_reg | drop;
    in_hist_next  = in_hist_reg << 1;
    in_hist_next[0]  = in_ready;
    out_hist_next = out_hist_reg << 1;
    out_hist_next[0] = out_ready;

    if (push) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;

    case ({push, pop})
      2'b10:   fill_next = fill_reg + 1'b1;
      2'b01:   fill_next = fill_reg - 1'b1;
      default: fill_next = fill_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      overflow_reg <= 1'b0;
      in_hist_reg  <= '0;
      out_hist_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fill_reg     <= fill_next;
      overflow_reg <= overflow_next;
      in_hist_reg  <= in_hist_next;
      out_hist_reg <= out_hist_next;
    end
  end

  // Storage needs no reset: entries are only observed once fill_reg says they were written.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= in_payload;
  end

endmodule

// File: tb/tb_avalon_st_timing_adapter_rl.sv
// Bench for avalon_st_timing_adapter_rl: three instances (RL0/RL0, OUT_RL=1, IN_RL=2),
// directed stimulus feeding per-instance expectation queues, negedge monitor compares.
module tb_avalon_st_timing_adapter_rl;
  localparam int PW = 42;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [3];
  logic          in_valid  [3];
  logic [PW-1:0] in_pay    [3];
  logic          in_ready  [3];
  logic          out_ready [3];
  logic          out_valid [3];
  logic [PW-1:0] out_pay   [3];
  logic [3:0]    fill      [3];
  logic          ovf       [3];

  int n_tests = 0;
  int n_fail  = 0;
  int rx [3];
  int acc;
  int tgt;
  logic prev_rdy1 = 1'b0;
  logic fill_mon  = 1'b0;
  logic [PW-1:0] q0 [$];
  logic [PW-1:0] q1 [$];
  logic [PW-1:0] q2 [$];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    avalon_st_timing_adapter_rl #(
      .IN_READY_LATENCY (gi == 2 ? 2 : 0),
      .OUT_READY_LATENCY(gi == 1 ? 1 : 0)
    ) u_dut (
      .clk              (clk),
      .reset            (rst[gi]),
      .in_ready         (in_ready[gi]),
      .in_valid         (in_valid[gi]),
      .in_data          (in_pay[gi][41:10]),
      .in_error         (in_pay[gi][9:4]),
      .in_startofpacket (in_pay[gi][3]),
      .in_endofpacket   (in_pay[gi][2]),
      .in_empty         (in_pay[gi][1:0]),
      .out_ready        (out_ready[gi]),
      .out_valid        (out_valid[gi]),
      .out_data         (out_pay[gi][41:10]),
      .out_error        (out_pay[gi][9:4]),
      .out_startofpacket(out_pay[gi][3]),
      .out_endofpacket  (out_pay[gi][2]),
      .out_empty        (out_pay[gi][1:0]),
      .fill_level       (fill[gi]),
      .overflow         (ovf[gi])
    );
  end

  function automatic logic [PW-1:0] mk(input int i);
    logic [31:0] d;
    d = 32'hA500_0000 + 32'(i);
    return {d, d[5:0], (i % 5 == 0), (i % 5 == 4), d[1:0]};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [PW-1:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  // Output monitor: every consumed beat is checked against the head of its queue.
  always @(negedge clk) begin
    logic [PW-1:0] e;
    bit have;
    for (int k = 0; k < 3; k++) begin
      if (out_valid[k] && (k == 1 || out_ready[k])) begin
        have = 1'b1;
        e = '0;
        case (k)
          0:       if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
          1:       if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
          default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
        endcase
        if (!have) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat inst%0d: got %0h expected none", k, out_pay[k]);
        end else begin
          chk($sformatf("beat_inst%0d", k), out_pay[k], e);
        end
        rx[k]++;
      end
    end
    if (out_valid[1]) chk("rl1_valid_needs_prior_ready", prev_rdy1, 1);
    prev_rdy1 = out_ready[1];
    if (fill_mon) chk("rl0_fill_le1", fill[0] <= 4'd1, 1);
  end

  // Ready-latency-0 source: holds each beat until in_ready is seen high.
  task automatic send_rl0(input int k, input int n, input int base, input int max_cyc,
                          output int accepted);
    int i = 0;
    accepted = 0;
    for (int c = 0; c < max_cyc && i < n; c++) begin
      @(posedge clk); #1;
      in_valid[k] = 1'b1;
      in_pay[k]   = mk(base + i);
      @(negedge clk);
      if (in_ready[k]) begin
        push_exp(k, mk(base + i));
        i++;
        accepted++;
      end
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  // Ready-latency-2 source: asserts valid exactly when in_ready was high two cycles earlier.
  task automatic send_rl2(input int cycles, input int base, output int accepted);
    logic [1:0] rh = 2'b00;
    accepted = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      in_valid[2] = rh[1];
      in_pay[2]   = mk(base + accepted);
      @(negedge clk);
      if (in_valid[2]) begin
        push_exp(2, mk(base + accepted));
        accepted++;
      end
      rh[1] = rh[0];
      rh[0] = in_ready[2];
    end
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
  endtask

  task automatic wait_rx(input int k, input int target, input int budget);
    int c = 0;
    while (rx[k] < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk($sformatf("rx_count_inst%0d", k), rx[k], target);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; in_valid[k] = 1'b0; in_pay[k] = '0; out_ready[k] = 1'b0; rx[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready[0], 0);
    chk("reset_out_valid", out_valid[0], 0);
    chk("reset_fill", fill[0], 0);
    chk("reset_overflow", ovf[0], 0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // RL0/RL0 streaming: 20 beats, 1-cycle latency keeps fill at most 1
    out_ready[0] = 1'b1;
    fill_mon = 1'b1;
    send_rl0(0, 20, 0, 40, acc);
    chk("stream_accepted", acc, 20);
    wait_rx(0, 20, 20);
    fill_mon = 1'b0;

    // Sink stalled: only DEPTH beats of 10 accepted
    out_ready[0] = 1'b0;
    send_rl0(0, 10, 100, 12, acc);
    chk("stall_accepted", acc, 8);
    @(negedge clk);
    chk("stall_fill", fill[0], 8);
    chk("stall_in_ready", in_ready[0], 0);
    chk("stall_overflow", ovf[0], 0);
    out_ready[0] = 1'b1;
    wait_rx(0, 28, 30);
    chk("stall_drained_fill", fill[0], 0);

    // IN_RL=2 with honoured latency and stalled sink: exactly DEPTH stored, no drop
    send_rl2(20, 200, acc);
    @(negedge clk);
    chk("rl2_accepted", acc, 8);
    chk("rl2_fill", fill[2], 8);
    chk("rl2_in_ready", in_ready[2], 0);
    chk("rl2_overflow_clean", ovf[2], 0);

    // IN_RL=2 valid forced while ungranted: beats dropped, overflow sticks
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid[2] = 1'b1;
      in_pay[2]   = mk(999);
    end
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(negedge clk);
    chk("rl2_overflow_set", ovf[2], 1);
    chk("rl2_fill_after_drop", fill[2], 8);
    out_ready[2] = 1'b1;
    wait_rx(2, 8, 30);
    chk("rl2_overflow_sticky", ovf[2], 1);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    chk("rl2_overflow_cleared", ovf[2], 0);

    // OUT_RL=1 with out_ready toggling 1010..
    fork
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #1;
          out_ready[1] = (c % 2 == 0);
        end
      end
      send_rl0(1, 10, 300, 38, acc);
    join
    chk("rl1_accepted", acc, 10);
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    wait_rx(1, 10, 30);

    // Reset with stored beats: everything discarded, then a fresh beat flows
    out_ready[0] = 1'b0;
    send_rl0(0, 5, 400, 10, acc);
    @(negedge clk);
    chk("prereset_fill", fill[0], 5);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    q0.delete();
    @(negedge clk);
    chk("in_reset_in_ready", in_ready[0], 0);
    chk("in_reset_out_valid", out_valid[0], 0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("postreset_fill", fill[0], 0);
    chk("postreset_out_valid", out_valid[0], 0);
    out_ready[0] = 1'b1;
    tgt = rx[0] + 1;
    send_rl0(0, 1, 500, 5, acc);
    chk("postreset_accepted", acc, 1);
    wait_rx(0, tgt, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
